tristate_bus_arbiter: RTL and testbench
=======================================

// Module: tristate_bus_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for a shared tristate bus built from per-requester tristate buffers.
//   Grants at most one requester at a time and drives that requester's data onto bus; all others stay Z.
//   Inserts turnaround cycles (bus released to Z) between owners so two drivers never overlap.
//   Sits between N requesting units and the shared bus; it is the only block allowed to drive bus enables.
// PARAMETERS
//   N_REQ      4   number of requesters (2..8)
//   DATA_W     8   bus width in bits
//   MAX_BURST  4   max consecutive cycles one owner may hold bus (>=1)
//   TURN_CYC   1   bus-idle (all Z) cycles after every release (>=1)
// PORTS
//   clk        in     1              rising-edge clock
//   rst        in     1              synchronous reset, active-high
//   req        in     N_REQ          req[i]=1: requester i wants bus
//   data_in    in     N_REQ*DATA_W   requester i data at [i*DATA_W +: DATA_W]
//   oe         out    N_REQ          registered one-hot-or-zero buffer enables
//   grant_id   out    log2(N_REQ)    index of current owner (valid when bus_busy=1)
//   bus_busy   out    1              1 while some oe bit is set
//   bus        inout  DATA_W         shared bus; data_in of owner when oe!=0, else all Z
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, oe=0, grant_id=0, bus_busy=0, burst_cnt=0, turn_cnt=0,
//     last_owner=N_REQ-1 (requester 0 has highest priority first). bus=Z in the same cycle oe clears.
//   Reset mid-grant: oe drops to 0 on that edge; no turnaround is inserted after reset.
//   States: IDLE, GRANT, TURN.
//   IDLE: oe=0. If req!=0 at edge: pick first set req scanning last_owner+1, +2, ... (mod N_REQ);
//     next cycle oe[g]=1, grant_id=g, bus_busy=1, burst_cnt=1, state=GRANT. Latency req->oe = 1 clock.
//   GRANT: bus = data_in[g] combinationally (no register on data path).
//     Release at edge when req[g]=0 OR burst_cnt==MAX_BURST: oe=0, last_owner=g, turn_cnt=1, ->TURN.
//     Otherwise burst_cnt++ and hold. Requests from others never pre-empt before release.
//   TURN: oe=0, bus=Z. When turn_cnt==TURN_CYC: go to IDLE-arbitration in the same edge, i.e. if any
//     req is set, grant the next owner directly (oe set at that edge); else ->IDLE. Else turn_cnt++.
//   Minimum gap between two owners = TURN_CYC cycles of all-Z; oe never has >1 bit set.
//   Round-robin wrap: after owner N_REQ-1, scan restarts at 0. Owner that just released is lowest priority;
//     if it is the only requester it is re-granted after turnaround (no starvation, no lockout).
//   Requester whose req drops between IDLE decision and grant still receives one grant cycle, then releases.
//   req changes during TURN are sampled only at the final TURN edge.
//   bus_busy == |oe at all times; grant_id holds last owner value while idle.
// TESTING
//   1. rst=1 2 clks, req=0 -> oe=0, bus_busy=0, bus=ZZZZZZZZ.
//   2. req=4'b0001, data_in[0]=8'hA5, held 2 clks then dropped -> oe=0001 one clk after req, bus=A5
//      while granted, then oe=0 and bus=Z for exactly TURN_CYC=1 clk.
//   3. req=4'b1111 held -> owners 0,1,2,3,0 in order, each exactly MAX_BURST=4 clks, 1 Z clk between.
//   4. req=4'b1000 only, held 12 clks -> owner 3 re-granted after each 4-clk burst + 1 Z clk.
//   5. owner 2 granted, rst=1 mid-burst -> oe=0 same edge; after rst release req=4'b0110 -> owner 1 first.
//   6. Every cycle, assert $onehot0(oe) and bus==Z whenever oe==0; no X on bus during any grant.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin owner sequencer for a shared tristate bus
module tristate_bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int TURN_CYC  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_W-1:0]     data_in,
    output logic [N_REQ-1:0]            oe,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        bus_busy,
    inout  wire  [DATA_W-1:0]           bus
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam int TC_W = $clog2(TURN_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

    state_t            state, state_n;
    logic [N_REQ-1:0]  oe_n;
    logic [ID_W-1:0]   grant_id_n;
    logic [BC_W-1:0]   burst_cnt, burst_cnt_n;
    logic [TC_W-1:0]   turn_cnt, turn_cnt_n;
    logic [ID_W-1:0]   last_owner, last_owner_n;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic              arbitrate;

    // Scan starts just past the previous owner, so it ends up lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!pick_valid && req[(int'(last_owner) + k) % N_REQ]) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'((int'(last_owner) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_n      = state;
        oe_n         = oe;
        grant_id_n   = grant_id;
        burst_cnt_n  = burst_cnt;
        turn_cnt_n   = turn_cnt;
        last_owner_n = last_owner;
        arbitrate    = 1'b0;
        case (state)
            S_IDLE: arbitrate = 1'b1;
            S_GRANT: begin
                if (!req[grant_id] || burst_cnt == BC_W'(MAX_BURST)) begin
                    oe_n         = '0;
                    last_owner_n = grant_id;
                    turn_cnt_n   = TC_W'(1);
                    state_n      = S_TURN;
                end else begin
                    burst_cnt_n = burst_cnt + BC_W'(1);
                end
            end
            S_TURN: begin
                if (turn_cnt == TC_W'(TURN_CYC)) begin
                    arbitrate = 1'b1;
                end else begin
                    turn_cnt_n = turn_cnt + TC_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
        // The last turnaround edge doubles as an idle arbitration edge.
        if (arbitrate) begin
            oe_n    = '0;
            state_n = S_IDLE;
            if (pick_valid) begin
                oe_n[pick_id] = 1'b1;
                grant_id_n    = pick_id;
                burst_cnt_n   = BC_W'(1);
                state_n       = S_GRANT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            oe         <= '0;
            grant_id   <= '0;
            burst_cnt  <= '0;
            turn_cnt   <= '0;
            last_owner <= ID_W'(N_REQ - 1);
        end else begin
            state      <= state_n;
            oe         <= oe_n;
            grant_id   <= grant_id_n;
            burst_cnt  <= burst_cnt_n;
            turn_cnt   <= turn_cnt_n;
            last_owner <= last_owner_n;
        end
    end

    assign bus_busy = |oe;
    assign bus      = bus_busy ? data_in[int'(grant_id)*DATA_W +: DATA_W] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - scoreboard bench for tristate_bus_arbiter
module tb_tristate_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  oe;
    logic [1:0]  grant_id;
    logic        bus_busy;
    wire  [7:0]  bus;

    // A released bus floats up to all ones, so an idle bus must read 8'hFF.
    pullup (bus);

    tristate_bus_arbiter #(
        .N_REQ(4), .DATA_W(8), .MAX_BURST(4), .TURN_CYC(1)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .oe(oe), .grant_id(grant_id), .bus_busy(bus_busy), .bus(bus)
    );

    typedef struct packed {
        logic [3:0] oe;
        logic       busy;
        logic [1:0] gid;
        logic [7:0] bus;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] dat [4];
    logic [1:0] gid_model;
    int         n_vec;
    int         n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Apply one cycle of inputs; queue the outputs expected after the sampling edge.
    task automatic drive(input logic r_rst, input logic [3:0] r_req, input logic v, input int own);
        exp_t e;
        rst = r_rst;
        req = r_req;
        @(posedge clk);
        #1;
        if (v) gid_model = 2'(own);
        if (r_rst) gid_model = 2'd0;
        e.oe   = v ? (4'b0001 << own) : 4'b0000;
        e.busy = v;
        e.gid  = gid_model;
        e.bus  = v ? dat[own] : 8'hFF;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("oe", 32'(oe), 32'(e.oe));
            check_val("bus_busy", 32'(bus_busy), 32'(e.busy));
            check_val("grant_id", 32'(grant_id), 32'(e.gid));
            check_val("bus", 32'(bus), 32'(e.bus));
        end
        check_val("oe_onehot0", 32'($onehot0(oe)), 32'd1);
        check_val("busy_eq_or_oe", 32'(bus_busy), 32'(|oe));
    end

    initial begin
        dat[0] = 8'hA5; dat[1] = 8'h3C; dat[2] = 8'h5A; dat[3] = 8'hC3;
        data_in   = {dat[3], dat[2], dat[1], dat[0]};
        rst       = 1'b1;
        req       = 4'b0000;
        gid_model = 2'd0;
        n_vec     = 0;
        n_err     = 0;

        repeat (2) drive(1'b1, 4'b0000, 1'b0, 0);

        // Single requester: grant after one clock, one Z cycle, direct re-grant at turnaround end.
        drive(1'b0, 4'b0001, 1'b1, 0);
        drive(1'b0, 4'b0001, 1'b1, 0);
        drive(1'b0, 4'b0000, 1'b0, 0);
        drive(1'b0, 4'b0001, 1'b1, 0);
        drive(1'b0, 4'b0000, 1'b0, 0);
        drive(1'b0, 4'b0000, 1'b0, 0);

        // Request dropped right after the decision still yields exactly one grant cycle.
        drive(1'b0, 4'b0010, 1'b1, 1);
        drive(1'b0, 4'b0000, 1'b0, 0);
        drive(1'b0, 4'b0000, 1'b0, 0);

        // All requesting: 0,1,2,3,0 with full bursts and one Z cycle between owners.
        drive(1'b1, 4'b0000, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            repeat (4) drive(1'b0, 4'b1111, 1'b1, k % 4);
            if (k < 4) drive(1'b0, 4'b1111, 1'b0, 0);
        end
        drive(1'b0, 4'b0000, 1'b0, 0);
        drive(1'b0, 4'b0000, 1'b0, 0);

        // Lone requester 3 is re-granted after each capped burst.
        for (int i = 0; i < 12; i++)
            drive(1'b0, 4'b1000, (i % 5) < 4, 3);
        drive(1'b0, 4'b0000, 1'b0, 0);
        drive(1'b0, 4'b0000, 1'b0, 0);

        // Reset mid-burst of owner 2; priority restarts at 0 with no turnaround.
        drive(1'b0, 4'b0100, 1'b1, 2);
        drive(1'b0, 4'b0100, 1'b1, 2);
        drive(1'b1, 4'b0100, 1'b0, 0);
        repeat (4) drive(1'b0, 4'b0110, 1'b1, 1);
        drive(1'b0, 4'b0110, 1'b0, 0);
        drive(1'b0, 4'b0110, 1'b1, 2);
        drive(1'b0, 4'b0000, 1'b0, 0);
        drive(1'b0, 4'b0000, 1'b0, 0);

        repeat (2) @(posedge clk);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
